stream_fifo: RTL

- Parametrised synchronous FIFO for 32-bit sample/data streams between acquisition and processing stages. Successor to the single-port valid/ack buffer.
- Adds full-depth usage, same-cycle write and read, and first-word-fall-through output.
- Adds level and almost-full status, an optional drop-on-full mode, sticky error flags, and a synchronous flush.

---
 rtl/stream_fifo_pkg.sv | 15 +
 rtl/stream_fifo_if.sv | 38 +++
 rtl/stream_fifo_mem.sv | 32 +++
 rtl/stream_fifo.sv | 115 +++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Purpose: shared defaults and depth derivation for the stream FIFO slice.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package stream_fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int DEF_ALMOST_FULL = 12;

    // Number of storage entries for a given pointer width.
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Purpose: write/read stream, status and error signals of the stream FIFO.
// Latency: n/a (wiring only).
// Backpressure: data_in_ready from the FIFO; data_out_read from the consumer.
// Modports: master = producer/consumer side, slave = FIFO side.
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  flush;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_read;
    logic [ADDR_WIDTH:0]   level;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, err_clr, data_in, data_in_valid, data_out_read,
        input  data_in_ready, data_out, data_out_valid, level,
               full, almost_full, overflow, underflow
    );

    modport slave (
        input  flush, err_clr, data_in, data_in_valid, data_out_read,
        output data_in_ready, data_out, data_out_valid, level,
               full, almost_full, overflow, underflow
    );

endinterface

// File: rtl/stream_fifo_mem.sv
// Purpose: simple dual-port register array, one write port and one read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; caller gates we.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    // Storage is intentionally not reset; validity is tracked by the level.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Purpose: first-word-fall-through stream FIFO with level/almost-full status and sticky errors.
// Latency: a word written on edge N is visible on data_out right after edge N.
// Backpressure: data_in_ready = !full (registered), or tied high with drop-on-full.
// Ports: clk, rst (async active-low), bus (stream_fifo_if.slave: stream, flush, status, errors).
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL    = DEF_ALMOST_FULL,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic         clk,
    input  logic         rst,
    stream_fifo_if.slave bus
);

    localparam int                DEPTH   = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] LVL_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);
    localparam bit                DROP    = (DROP_WHEN_FULL != 0);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_d;
    logic                  full_q;
    logic                  almost_full_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] rdata;

    logic wr_en;
    logic rd_en;
    logic overflow_evt;
    logic underflow_evt;

    // Full gates writes even when a read happens in the same cycle, so the
    // ready path never depends combinationally on data_out_read.
    assign wr_en = bus.data_in_valid && !full_q && !bus.flush;
    assign rd_en = bus.data_out_read && valid_q && !bus.flush;

    // Error events are based on the attempt, independent of flush.
    assign overflow_evt  = DROP && bus.data_in_valid && full_q;
    assign underflow_evt = bus.data_out_read && !valid_q;

    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Status flags track the next level so they move on the same edge.
            level_q       <= level_d;
            full_q        <= (level_d == DEPTH_L);
            almost_full_q <= (level_d >= AF_L);
            valid_q       <= (level_d != '0);
            // Sticky errors: a new event beats a same-cycle clear.
            if (overflow_evt)     overflow_q <= 1'b1;
            else if (bus.err_clr) overflow_q <= 1'b0;
            if (underflow_evt)    underflow_q <= 1'b1;
            else if (bus.err_clr) underflow_q <= 1'b0;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.data_in_ready  = DROP ? 1'b1 : !full_q;
    assign bus.data_out       = valid_q ? rdata : '0;
    assign bus.data_out_valid = valid_q;
    assign bus.level          = level_q;
    assign bus.full           = full_q;
    assign bus.almost_full    = almost_full_q;
    assign bus.overflow       = overflow_q;
    assign bus.underflow      = underflow_q;

endmodule
